// File: rtl/fwrisc_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fwrisc_fetch_if
//  Description : Signal bundle between the fetch stage, the execute stage and
//                the 32-bit instruction bus. The master modport is the fetch
//                stage; the slave modport is its environment (execute + memory).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fwrisc_fetch_if;
    // Execute-stage side
    logic [31:0] pc;
    logic        pc_seq;
    logic        instr_complete;
    logic        fetch_valid;
    logic [31:0] instr;
    logic        instr_c;
    // Instruction bus side
    logic [31:0] iaddr;
    logic        ivalid;
    logic [31:0] idata;
    logic        iready;

    modport master (
        input  pc, pc_seq, instr_complete, idata, iready,
        output iaddr, ivalid, fetch_valid, instr, instr_c
    );

    modport slave (
        output pc, pc_seq, instr_complete, idata, iready,
        input  iaddr, ivalid, fetch_valid, instr, instr_c
    );
endinterface
`default_nettype wire

// File: rtl/fwrisc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : fwrisc_fetch
//  Description : Instruction fetch stage. Reads words from the instruction
//                bus at the PC published by execute and holds one instruction
//                until execute pulses instr_complete. With the macro
//                FWRISC_FETCH_COMPRESSED_EN defined it also assembles 16-bit
//                compressed instructions and 32-bit instructions straddling a
//                word boundary, using a one half-word buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwrisc_fetch (
    input  logic          clock,
    input  logic          reset,
    fwrisc_fetch_if.master bus
);

    localparam logic [1:0] C_FETCH1 = 2'd0;
`ifdef FWRISC_FETCH_COMPRESSED_EN
    localparam logic [1:0] C_FETCH2 = 2'd1;
`endif
    localparam logic [1:0] C_WAIT   = 2'd2;

    logic [1:0]  state_q,       state_d;
    logic        ivalid_q,      ivalid_d;
    logic [31:0] iaddr_q,       iaddr_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] instr_q,       instr_d;

`ifdef FWRISC_FETCH_COMPRESSED_EN
    logic        instr_c_q,     instr_c_d;
    logic [31:1] pc_q,          pc_d;       // half-word PC of the fetch in flight
    logic [15:0] hbuf_q,        hbuf_d;
    logic [31:1] hbuf_addr_q,   hbuf_addr_d;
    logic        hbuf_valid_q,  hbuf_valid_d;
    logic        hit_q,         hit_d;      // buffer hit waiting to be presented
    logic        w_hit;
`endif

    logic w_ack;
    logic w_done;

    assign w_ack  = ivalid_q & bus.iready;
    assign w_done = (state_q == C_WAIT) & fetch_valid_q & bus.instr_complete;

`ifdef FWRISC_FETCH_COMPRESSED_EN
    // The next sequential half-word is already buffered and is itself compressed
    assign w_hit = bus.pc_seq & hbuf_valid_q & (hbuf_addr_q == bus.pc[31:1])
                 & (hbuf_q[1:0] != 2'b11);
`endif

    // Next-state logic for the fetch FSM, bus request and presented instruction
    always_comb begin
        state_d       = state_q;
        ivalid_d      = ivalid_q;
        iaddr_d       = iaddr_q;
        fetch_valid_d = fetch_valid_q;
        instr_d       = instr_q;
`ifdef FWRISC_FETCH_COMPRESSED_EN
        instr_c_d     = instr_c_q;
        pc_d          = pc_q;
        hbuf_d        = hbuf_q;
        hbuf_addr_d   = hbuf_addr_q;
        hbuf_valid_d  = hbuf_valid_q;
        hit_d         = hit_q;
`endif
        case (state_q)
            C_FETCH1: begin
                if (!ivalid_q) begin
                    // First request after reset: launch at the published PC
                    ivalid_d = 1'b1;
                    iaddr_d  = {bus.pc[31:2], 2'b00};
`ifdef FWRISC_FETCH_COMPRESSED_EN
                    pc_d     = bus.pc[31:1];
`endif
                end else if (w_ack) begin
                    ivalid_d      = 1'b0;
                    fetch_valid_d = 1'b1;
                    state_d       = C_WAIT;
`ifdef FWRISC_FETCH_COMPRESSED_EN
                    if (!pc_q[1]) begin
                        if (bus.idata[1:0] != 2'b11) begin
                            instr_d      = {16'h0000, bus.idata[15:0]};
                            instr_c_d    = 1'b1;
                            hbuf_d       = bus.idata[31:16];
                            hbuf_addr_d  = pc_q + 31'd1;
                            hbuf_valid_d = 1'b1;
                        end else begin
                            instr_d      = bus.idata;
                            instr_c_d    = 1'b0;
                        end
                    end else if (bus.idata[17:16] != 2'b11) begin
                        instr_d   = {16'h0000, bus.idata[31:16]};
                        instr_c_d = 1'b1;
                    end else begin
                        // Upper half starts a 32-bit instruction: fetch the next word
                        hbuf_d        = bus.idata[31:16];
                        hbuf_valid_d  = 1'b0;
                        ivalid_d      = 1'b1;
                        fetch_valid_d = 1'b0;
                        iaddr_d       = iaddr_q + 32'd4;
                        state_d       = C_FETCH2;
                    end
`else
                    instr_d = bus.idata;
`endif
                end
            end
`ifdef FWRISC_FETCH_COMPRESSED_EN
            C_FETCH2: begin
                if (w_ack) begin
                    instr_d       = {bus.idata[15:0], hbuf_q};
                    instr_c_d     = 1'b0;
                    hbuf_d        = bus.idata[31:16];
                    hbuf_addr_d   = pc_q + 31'd2;
                    hbuf_valid_d  = 1'b1;
                    ivalid_d      = 1'b0;
                    fetch_valid_d = 1'b1;
                    state_d       = C_WAIT;
                end
            end
`endif
            C_WAIT: begin
`ifdef FWRISC_FETCH_COMPRESSED_EN
                if (hit_q) begin
                    // Present the buffered half after the one-cycle bubble
                    instr_d       = {16'h0000, hbuf_q};
                    instr_c_d     = 1'b1;
                    fetch_valid_d = 1'b1;
                    hit_d         = 1'b0;
                end else if (w_done) begin
                    fetch_valid_d = 1'b0;
                    if (!bus.pc_seq) begin
                        hbuf_valid_d = 1'b0;
                    end
                    if (w_hit) begin
                        hit_d        = 1'b1;
                        hbuf_valid_d = 1'b0;
                    end else begin
                        ivalid_d = 1'b1;
                        iaddr_d  = {bus.pc[31:2], 2'b00};
                        pc_d     = bus.pc[31:1];
                        state_d  = C_FETCH1;
                    end
                end
`else
                if (w_done) begin
                    fetch_valid_d = 1'b0;
                    ivalid_d      = 1'b1;
                    iaddr_d       = {bus.pc[31:2], 2'b00};
                    state_d       = C_FETCH1;
                end
`endif
            end
            default: begin
                state_d = C_FETCH1;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= C_FETCH1;
            ivalid_q      <= 1'b0;
            iaddr_q       <= 32'h0000_0000;
            fetch_valid_q <= 1'b0;
            instr_q       <= 32'h0000_0000;
`ifdef FWRISC_FETCH_COMPRESSED_EN
            instr_c_q     <= 1'b0;
            pc_q          <= 31'h0;
            hbuf_q        <= 16'h0000;
            hbuf_addr_q   <= 31'h0;
            hbuf_valid_q  <= 1'b0;
            hit_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ivalid_q      <= ivalid_d;
            iaddr_q       <= iaddr_d;
            fetch_valid_q <= fetch_valid_d;
            instr_q       <= instr_d;
`ifdef FWRISC_FETCH_COMPRESSED_EN
            instr_c_q     <= instr_c_d;
            pc_q          <= pc_d;
            hbuf_q        <= hbuf_d;
            hbuf_addr_q   <= hbuf_addr_d;
            hbuf_valid_q  <= hbuf_valid_d;
            hit_q         <= hit_d;
`endif
        end
    end

    assign bus.ivalid      = ivalid_q;
    assign bus.iaddr       = iaddr_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.instr       = instr_q;
`ifdef FWRISC_FETCH_COMPRESSED_EN
    assign bus.instr_c     = instr_c_q;
`else
    assign bus.instr_c     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwrisc_fetch
//  Description : Directed self-checking bench for fwrisc_fetch. A vector
//                table covers single-access fetches; hand sequences cover
//                buffer hits, straddling fetches, wrap-around and reset while
//                a request is outstanding. Follows FWRISC_FETCH_COMPRESSED_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwrisc_fetch;

    logic clock;
    logic reset;
    int   n_total;
    int   n_pass;

    fwrisc_fetch_if bus ();

    fwrisc_fetch u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
        logic [31:0] instr;
        logic        c;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Wait (bounded) for a request, check its address, hold off, then ack once
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data, input int delay);
        int n;
        n = 0;
        while (bus.ivalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'h0, bus.ivalid}, 32'h1);
        chk("iaddr", bus.iaddr, exp_addr);
        for (int k = 0; k < delay; k++) begin
            tick();
            chk("iaddr_hold", bus.iaddr, exp_addr);
            chk("ivalid_hold", {31'h0, bus.ivalid}, 32'h1);
        end
        bus.idata  = data;
        bus.iready = 1'b1;
        tick();
        bus.iready = 1'b0;
        bus.idata  = 32'h0;
    endtask

    task automatic complete(input logic [31:0] new_pc, input logic seq);
        bus.pc             = new_pc;
        bus.pc_seq         = seq;
        bus.instr_complete = 1'b1;
        tick();
        bus.instr_complete = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [31:0] instr, input logic c);
        chk({name, "_fv"}, {31'h0, bus.fetch_valid}, 32'h1);
        chk({name, "_instr"}, bus.instr, instr);
        chk({name, "_c"}, {31'h0, bus.instr_c}, {31'h0, c});
        chk({name, "_ivalid"}, {31'h0, bus.ivalid}, 32'h0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b1;
        bus.pc             = 32'h8000_0000;
        bus.pc_seq         = 1'b0;
        bus.instr_complete = 1'b0;
        bus.idata          = 32'h0;
        bus.iready         = 1'b0;

`ifdef FWRISC_FETCH_COMPRESSED_EN
        vecs[0] = '{32'h8000_0000, 32'h8000_0000, 32'h0050_0093, 2, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h8000_0010, 32'h8000_0010, 32'h1234_0001, 0, 32'h0000_0001, 1'b1};
        vecs[2] = '{32'h8000_0022, 32'h8000_0020, 32'h4501_ABCD, 1, 32'h0000_4501, 1'b1};
        vecs[3] = '{32'h0000_0107, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0000_DEAD, 1'b1};
`else
        vecs[0] = '{32'h8000_0000, 32'h8000_0000, 32'h0050_0093, 2, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h8000_0002, 32'h8000_0000, 32'h4501_4505, 0, 32'h4501_4505, 1'b0};
        vecs[2] = '{32'h0000_0107, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h1234_5678, 1, 32'h1234_5678, 1'b0};
`endif

        // Reset state
        repeat (3) tick();
        chk("rst_ivalid", {31'h0, bus.ivalid}, 32'h0);
        chk("rst_iaddr", bus.iaddr, 32'h0);
        chk("rst_fv", {31'h0, bus.fetch_valid}, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_c", {31'h0, bus.instr_c}, 32'h0);
        reset = 1'b0;
        tick();
        chk("first_req", {31'h0, bus.ivalid}, 32'h1);

        // Table-driven single-access fetches
        for (int i = 0; i < 4; i++) begin
            if (i > 0) complete(vecs[i].pc, 1'b0);
            serve(vecs[i].addr, vecs[i].data, vecs[i].delay);
            chk_out("vec", vecs[i].instr, vecs[i].c);
        end

`ifdef FWRISC_FETCH_COMPRESSED_EN
        // Compressed pair: second half comes from the buffer after one bubble
        complete(32'h8000_0000, 1'b0);
        serve(32'h8000_0000, 32'h4501_4505, 0);
        chk_out("pair0", 32'h0000_4505, 1'b1);
        complete(32'h8000_0002, 1'b1);
        chk("hit_bubble_fv", {31'h0, bus.fetch_valid}, 32'h0);
        chk("hit_no_req", {31'h0, bus.ivalid}, 32'h0);
        tick();
        chk_out("pair1", 32'h0000_4501, 1'b1);

        // Straddling 32-bit instruction: two word accesses
        complete(32'h8000_0002, 1'b0);
        serve(32'h8000_0000, 32'h0093_0001, 0);
        chk("strad_fv_low", {31'h0, bus.fetch_valid}, 32'h0);
        serve(32'h8000_0004, 32'h1234_0050, 1);
        chk_out("strad", 32'h0050_0093, 1'b0);

        // Non-sequential completion discards the buffered half at 0x8000_0006
        complete(32'h8000_0100, 1'b0);
        chk("jump_req", {31'h0, bus.ivalid}, 32'h1);
        chk("jump_addr", bus.iaddr, 32'h8000_0100);
        serve(32'h8000_0100, 32'h0000_0013, 0);
        chk_out("jump", 32'h0000_0013, 1'b0);
        complete(32'h8000_0006, 1'b1);
        chk("stale_buf_req", {31'h0, bus.ivalid}, 32'h1);
        serve(32'h8000_0004, 32'h4502_0000, 0);
        chk_out("stale", 32'h0000_4502, 1'b1);

        // Straddle across the top of the address space wraps to 0
        complete(32'hFFFF_FFFE, 1'b0);
        serve(32'hFFFF_FFFC, 32'h0093_0000, 0);
        serve(32'h0000_0000, 32'h0000_0050, 0);
        chk_out("wrap", 32'h0050_0093, 1'b0);
`else
        // Sequential completion still fetches the whole word from the bus
        complete(32'h8000_0002, 1'b1);
        chk("seq_req", {31'h0, bus.ivalid}, 32'h1);
        serve(32'h8000_0000, 32'h4501_4505, 0);
        chk_out("seq", 32'h4501_4505, 1'b0);
`endif

        // Reset while a request is outstanding; a late ack must be ignored
        complete(32'h8000_0200, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_ivalid", {31'h0, bus.ivalid}, 32'h1);
            chk("stall_iaddr", bus.iaddr, 32'h8000_0200);
            tick();
        end
        reset = 1'b1;
        tick();
        chk("mid_rst_ivalid", {31'h0, bus.ivalid}, 32'h0);
        chk("mid_rst_fv", {31'h0, bus.fetch_valid}, 32'h0);
        bus.idata  = 32'hBAD0_BAD0;
        bus.iready = 1'b1;
        tick();
        chk("late_ack_fv", {31'h0, bus.fetch_valid}, 32'h0);
        reset      = 1'b0;
        bus.iready = 1'b0;
        bus.idata  = 32'h0;
        tick();
        chk("post_rst_fv", {31'h0, bus.fetch_valid}, 32'h0);
        serve(32'h8000_0200, 32'h0010_0113, 0);
        chk_out("post_rst", 32'h0010_0113, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
